// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the nibble-serial subtractor:
//   - default operand width and nibble size
//   - FSM state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package sub_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int NIBBLE_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sub_pkg

// File: rtl/rcs_4bit.sv
// -----------------------------------------------------------------------------
// rcs_4bit
// Combinational 4-bit ripple subtractor: diff = a - b - borrow_in.
// Implemented as a + ~b + ~borrow_in through a carry chain (borrow = ~carry).
// Ports:
//   a, b       : nibble operands
//   borrow_in  : borrow into bit 0
//   diff       : nibble result
//   borrow_out : borrow out of bit 3
//   carry_msb  : carry into bit 3 (used with carry-out for overflow)
// -----------------------------------------------------------------------------
module rcs_4bit
   import sub_pkg::*;
(
   input  logic [NIBBLE_DEF-1:0] a,
   input  logic [NIBBLE_DEF-1:0] b,
   input  logic                  borrow_in,
   output logic [NIBBLE_DEF-1:0] diff,
   output logic                  borrow_out,
   output logic                  carry_msb
);

   logic [NIBBLE_DEF:0]   carry_s;
   logic [NIBBLE_DEF-1:0] diff_s;
   logic [NIBBLE_DEF-1:0] nb_s;

   // Ripple carry chain over a + ~b with carry-in = ~borrow_in
   always_comb begin
      carry_s    = '0;
      diff_s     = '0;
      nb_s       = ~b;
      carry_s[0] = ~borrow_in;
      for (int i = 0; i < NIBBLE_DEF; i++) begin
         diff_s[i]    = a[i] ^ nb_s[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & nb_s[i]) | (carry_s[i] & (a[i] ^ nb_s[i]));
      end
   end

   assign diff       = diff_s;
   assign borrow_out = ~carry_s[NIBBLE_DEF];
   assign carry_msb  = carry_s[NIBBLE_DEF-1];

endmodule : rcs_4bit

// File: rtl/serial_sub_16bit.sv
// -----------------------------------------------------------------------------
// serial_sub_16bit
// Nibble-serial subtractor: diff = a - b - borrow_in (mod 2^WIDTH), one
// nibble per clock, LSB first, through a single shared rcs_4bit.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : accepted in IDLE or DONE; latches a, b, borrow_in
//   a, b        : minuend / subtrahend
//   borrow_in   : borrow into the LSB nibble
//   busy        : high while nibbles are computed (RUN)
//   done        : one-cycle pulse, result valid (DONE)
//   diff        : result, held until the next accepted start
//   borrow_out  : unsigned borrow out of the MSB
//   overflow    : two's-complement overflow
// -----------------------------------------------------------------------------
module serial_sub_16bit
   import sub_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NIBBLE = NIBBLE_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int NUM_NIB = WIDTH / NIBBLE;
   localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NIB - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             nb_r;      // borrow carried between nibbles

   logic [NIBBLE-1:0] a_nib_s;
   logic [NIBBLE-1:0] b_nib_s;
   logic [NIBBLE-1:0] d_nib_s;
   logic              bout_nib_s;
   logic              cmsb_nib_s;

   // Select the current nibble of the latched operands
   always_comb begin
      a_nib_s = a_r[cnt_r*NIBBLE +: NIBBLE];
      b_nib_s = b_r[cnt_r*NIBBLE +: NIBBLE];
   end

   rcs_4bit u_rcs (
      .a          (a_nib_s),
      .b          (b_nib_s),
      .borrow_in  (nb_r),
      .diff       (d_nib_s),
      .borrow_out (bout_nib_s),
      .carry_msb  (cmsb_nib_s)
   );

   // Control FSM with counter, operand/result registers and registered flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         a_r        <= '0;
         b_r        <= '0;
         nb_r       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  nb_r    <= borrow_in;
                  cnt_r   <= '0;
                  diff    <= '0;
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               diff[cnt_r*NIBBLE +: NIBBLE] <= d_nib_s;
               nb_r                         <= bout_nib_s;
               if (cnt_r == CNT_LAST) begin
                  // Overflow: carry into MSB differs from carry out of MSB
                  borrow_out <= bout_nib_s;
                  overflow   <= cmsb_nib_s ^ ~bout_nib_s;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  cnt_r      <= cnt_r + CNT_ONE;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  state_r    <= RUN;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule : serial_sub_16bit
